// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_rx_pkg;

  // Packet type reported to the protocol controller
  typedef enum logic [2:0] {
    RX_NONE  = 3'd0,
    RX_OUT   = 3'd1,
    RX_IN    = 3'd2,
    RX_DATA0 = 3'd3,
    RX_DATA1 = 3'd4,
    RX_ACK   = 3'd5,
    RX_NAK   = 3'd6,
    RX_STALL = 3'd7
  } rx_pkt_t;

  // PID values as they appear in the lower nibble of the PID byte
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // KJKJKJKK decodes to 0x80 when assembled LSB-first
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SYNC  = 4'd1,
    S_PID   = 4'd2,
    S_TOKEN = 4'd3,
    S_DATA  = 4'd4,
    S_EOP   = 4'd5,
    S_EOP_J = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } rx_state_t;

  // Map a received PID byte to a packet type; RX_NONE flags a bad or unsupported PID
  function automatic rx_pkt_t pid_decode(input logic [7:0] pid_byte);
    rx_pkt_t pkt;
    pkt = RX_NONE;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_byte[3:0])
        PID_OUT:   pkt = RX_OUT;
        PID_IN:    pkt = RX_IN;
        PID_DATA0: pkt = RX_DATA0;
        PID_DATA1: pkt = RX_DATA1;
        PID_ACK:   pkt = RX_ACK;
        PID_NAK:   pkt = RX_NAK;
        PID_STALL: pkt = RX_STALL;
        default:   pkt = RX_NONE;
      endcase
    end else begin
      pkt = RX_NONE;
    end
    return pkt;
  endfunction

endpackage

// File: rtl/usb_rx_unstuff_bit_decoder.sv
// Line front end: synchronizers, bit timer, NRZI decode, unstuffing and SE0 detection.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dp_in,
  input  logic dm_in,
  input  logic idle,
  output logic start,
  output logic strobe,
  output logic line_j,
  output logic bit_valid,
  output logic bit_val,
  output logic eop_seen,
  output logic stuff_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  logic          dp_meta_r, dp_sync_r, dm_meta_r, dm_sync_r, dp_prev_r;
  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic          nrzi_prev_r;
  logic [2:0]    ones_r;
  logic          sample_s, se0_s, dec_s, dp_edge_s;

  assign dp_edge_s = dp_sync_r ^ dp_prev_r;
  // First J->K while the packet FSM is idle marks the start of SYNC
  assign start     = idle & dp_prev_r & ~dp_sync_r;
  assign sample_s  = active_r & ~idle & (cnt_r == CNT_HALF);
  assign se0_s     = ~dp_sync_r & ~dm_sync_r;
  // NRZI: no level change means a 1
  assign dec_s     = (dp_sync_r == nrzi_prev_r);

  // Two-flop synchronizers (idle J) plus a delayed dp copy for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_r <= 1'b1;
      dp_sync_r <= 1'b1;
      dm_meta_r <= 1'b0;
      dm_sync_r <= 1'b0;
      dp_prev_r <= 1'b1;
    end else begin
      dp_meta_r <= dp_in;
      dp_sync_r <= dp_meta_r;
      dm_meta_r <= dm_in;
      dm_sync_r <= dm_meta_r;
      dp_prev_r <= dp_sync_r;
    end
  end

  // Bit timer: started by the first K, resynchronized on every dp transition
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
    end else if (idle) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
    end else if (dp_edge_s || (cnt_r == CNT_LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Mid-bit sampling: SE0 detection, NRZI decode and removal of stuffed zeros
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe      <= 1'b0;
      line_j      <= 1'b1;
      bit_valid   <= 1'b0;
      bit_val     <= 1'b0;
      eop_seen    <= 1'b0;
      stuff_err   <= 1'b0;
      nrzi_prev_r <= 1'b1;
      ones_r      <= 3'd0;
    end else begin
      strobe    <= 1'b0;
      bit_valid <= 1'b0;
      eop_seen  <= 1'b0;
      stuff_err <= 1'b0;
      if (start) begin
        nrzi_prev_r <= 1'b1;
        ones_r      <= 3'd0;
      end else if (sample_s) begin
        strobe <= 1'b1;
        line_j <= dp_sync_r & ~dm_sync_r;
        if (se0_s) begin
          eop_seen <= 1'b1;
          ones_r   <= 3'd0;
        end else begin
          nrzi_prev_r <= dp_sync_r;
          if (ones_r == 3'd6) begin
            ones_r    <= 3'd0;
            stuff_err <= dec_s;
          end else begin
            bit_valid <= 1'b1;
            bit_val   <= dec_s;
            ones_r    <= dec_s ? (ones_r + 3'd1) : 3'd0;
          end
        end
      end else begin
        nrzi_prev_r <= nrzi_prev_r;
        ones_r      <= ones_r;
      end
    end
  end

endmodule

// File: rtl/usb_rx_unstuff.sv
// Full-speed USB receiver top: byte assembly and packet FSM over the bit decoder.
module usb_rx_unstuff
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int BUF_DEPTH    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic [6:0] buffer_occupancy,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error
);

  rx_state_t  state_r, next_state;
  logic       start_s, strobe_s, line_j_s, bit_valid_s, bit_val_s, eop_seen_s, stuff_err_s;
  logic [2:0] bit_cnt_r;
  logic [6:0] shreg_r;
  logic [7:0] byte_s;
  logic       byte_valid_s, partial_s, buf_full_s, err_s;
  rx_pkt_t    pid_pkt_s;
  logic       tok_cnt_r, is_data_r, got_byte_r;
  logic [2:0] j_cnt_r;
  logic       store_n, err_n, rdy_n, act_n;
  logic [7:0] data_n;
  logic [2:0] pkt_n;

  usb_rx_bit_decoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dec (
    .clk       (clk),
    .n_rst     (n_rst),
    .dp_in     (dp_in),
    .dm_in     (dm_in),
    .idle      (state_r == S_IDLE),
    .start     (start_s),
    .strobe    (strobe_s),
    .line_j    (line_j_s),
    .bit_valid (bit_valid_s),
    .bit_val   (bit_val_s),
    .eop_seen  (eop_seen_s),
    .stuff_err (stuff_err_s)
  );

  assign byte_valid_s = bit_valid_s & (bit_cnt_r == 3'd7);
  assign byte_s       = {bit_val_s, shreg_r};
  assign partial_s    = (bit_cnt_r != 3'd0);
  assign buf_full_s   = (buffer_occupancy >= 7'(BUF_DEPTH));
  assign pid_pkt_s    = pid_decode(byte_s);
  assign err_s        = stuff_err_s | (eop_seen_s & partial_s) |
                        ((state_r == S_DATA) & byte_valid_s & buf_full_s);

  // LSB-first byte assembler, cleared whenever the receiver is idle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_r <= 3'd0;
      shreg_r   <= 7'd0;
    end else if (state_r == S_IDLE) begin
      bit_cnt_r <= 3'd0;
      shreg_r   <= 7'd0;
    end else if (bit_valid_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shreg_r   <= {bit_val_s, shreg_r[6:1]};
    end else begin
      bit_cnt_r <= bit_cnt_r;
      shreg_r   <= shreg_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // FSM next-state logic; errors take priority over byte completion
  always_comb begin
    next_state = state_r;
    case (state_r)
      S_IDLE:  next_state = start_s ? S_SYNC : S_IDLE;
      S_SYNC: begin
        if (err_s || eop_seen_s)  next_state = S_ERR;
        else if (byte_valid_s)    next_state = (byte_s == SYNC_BYTE) ? S_PID : S_ERR;
        else                      next_state = S_SYNC;
      end
      S_PID: begin
        if (err_s || eop_seen_s) begin
          next_state = S_ERR;
        end else if (byte_valid_s) begin
          case (pid_pkt_s)
            RX_OUT, RX_IN:           next_state = S_TOKEN;
            RX_DATA0, RX_DATA1:      next_state = S_DATA;
            RX_ACK, RX_NAK, RX_STALL: next_state = S_EOP;
            default:                 next_state = S_ERR;
          endcase
        end else begin
          next_state = S_PID;
        end
      end
      S_TOKEN: begin
        if (err_s || eop_seen_s)         next_state = S_ERR;
        else if (byte_valid_s && tok_cnt_r) next_state = S_EOP;
        else                             next_state = S_TOKEN;
      end
      S_DATA: begin
        if (err_s)           next_state = S_ERR;
        else if (eop_seen_s) next_state = S_EOP_J;
        else                 next_state = S_DATA;
      end
      S_EOP: begin
        if (err_s)         next_state = S_ERR;
        else if (strobe_s) next_state = eop_seen_s ? S_EOP_J : S_ERR;
        else               next_state = S_EOP;
      end
      S_EOP_J: begin
        if (err_s)                      next_state = S_ERR;
        else if (strobe_s && line_j_s)  next_state = S_DONE;
        else                            next_state = S_EOP_J;
      end
      S_DONE:  next_state = S_IDLE;
      S_ERR: begin
        if (strobe_s && line_j_s && (j_cnt_r == 3'd7)) next_state = S_IDLE;
        else                                           next_state = S_ERR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered status outputs
  always_comb begin
    store_n = 1'b0;
    data_n  = rx_packet_data;
    pkt_n   = rx_packet;
    err_n   = rx_error;
    rdy_n   = rx_data_ready;
    act_n   = rx_transfer_active;
    if ((state_r == S_DATA) && byte_valid_s && !err_s) begin
      store_n = 1'b1;
      data_n  = byte_s;
    end else begin
      store_n = 1'b0;
    end
    if (start_s) begin
      pkt_n = RX_NONE;
      err_n = 1'b0;
      rdy_n = 1'b0;
      act_n = 1'b1;
    end else begin
      if ((state_r == S_PID) && (next_state inside {S_TOKEN, S_DATA, S_EOP})) begin
        pkt_n = pid_pkt_s;
      end else begin
        pkt_n = rx_packet;
      end
      if ((next_state == S_ERR) && (state_r != S_ERR)) begin
        err_n = 1'b1;
      end else begin
        err_n = rx_error;
      end
      if (next_state == S_DONE) begin
        rdy_n = is_data_r & got_byte_r;
        act_n = 1'b0;
      end else if ((state_r == S_ERR) && (next_state == S_IDLE)) begin
        act_n = 1'b0;
      end else begin
        act_n = rx_transfer_active;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_packet_data       <= 8'h00;
      store_rx_packet_data <= 1'b0;
      rx_packet            <= RX_NONE;
      rx_data_ready        <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_error             <= 1'b0;
    end else begin
      rx_packet_data       <= data_n;
      store_rx_packet_data <= store_n;
      rx_packet            <= pkt_n;
      rx_data_ready        <= rdy_n;
      rx_transfer_active   <= act_n;
      rx_error             <= err_n;
    end
  end

  // Per-packet context: token byte count, idle-J run length, data-packet tracking
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tok_cnt_r  <= 1'b0;
      j_cnt_r    <= 3'd0;
      is_data_r  <= 1'b0;
      got_byte_r <= 1'b0;
    end else begin
      if (state_r != S_TOKEN)  tok_cnt_r <= 1'b0;
      else if (byte_valid_s)   tok_cnt_r <= 1'b1;
      else                     tok_cnt_r <= tok_cnt_r;
      if (state_r != S_ERR)    j_cnt_r <= 3'd0;
      else if (strobe_s)       j_cnt_r <= line_j_s ? (j_cnt_r + 3'd1) : 3'd0;
      else                     j_cnt_r <= j_cnt_r;
      if (start_s)                                          is_data_r <= 1'b0;
      else if ((state_r == S_PID) && (next_state == S_DATA)) is_data_r <= 1'b1;
      else                                                  is_data_r <= is_data_r;
      if (start_s)      got_byte_r <= 1'b0;
      else if (store_n) got_byte_r <= 1'b1;
      else              got_byte_r <= got_byte_r;
    end
  end

endmodule

// File: doc/usb_rx_unstuff.md
Name: usb_rx_unstuff

Overview:
Full-speed USB receive path, the counterpart of the transmit path (tx control unit, timer, shift register, bit stuffer, NRZI encoder).
- Samples the D+/D- line pair and recovers bit timing.
- NRZI-decodes and removes stuffed bits.
- Validates SYNC and PID, and streams payload bytes into the shared packet buffer.
- Reports the packet type and error status to the USB protocol controller.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time; must be even and at least 4.
BUF_DEPTH, 64, packet buffer capacity in bytes; compared against buffer_occupancy.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous reset, active low
dp_in  input  1  raw D+ line (asynchronous)
dm_in  input  1  raw D- line (asynchronous)
buffer_occupancy  input  7  current byte count in the packet buffer
rx_packet_data  output  8  assembled payload byte
store_rx_packet_data  output  1  one-cycle write strobe for rx_packet_data
rx_packet  output  3  decoded packet type (rx_pkt_t)
rx_data_ready  output  1  valid data packet received; buffer holds its payload
rx_transfer_active  output  1  packet reception in progress
rx_error  output  1  packet rejected

Behaviour:
- Reset values:
  - rx_packet_data = 0x00
  - store_rx_packet_data = 0
  - rx_packet = RX_NONE (0)
  - rx_data_ready = 0
  - rx_transfer_active = 0
  - rx_error = 0
  - Synchronizers reset to idle J: dp = 1, dm = 0.
- Input synchronization: two-flop synchronizer on each line. All logic uses the synchronized values.
- Bit timing:
  - In IDLE, the first dp falling edge (J to K) starts the bit counter at 0.
  - The counter wraps at CLKS_PER_BIT-1 and is reset to 0 on every dp transition, which resynchronizes it.
  - Sample strobe fires at count == CLKS_PER_BIT/2.
- Line decoding at each strobe:
  - SE0 (dp = 0, dm = 0) produces eop_seen.
  - Otherwise NRZI decoding applies: bit = 1 if the sample equals the previous sample, else 0.
- Unstuffing:
  - After 6 consecutive decoded 1s, the next bit is dropped and the ones-counter clears.
  - If that dropped bit is 1, stuff_err is raised.
- Bytes assemble LSB-first. byte_valid pulses one clock after the strobe of the 8th unstuffed bit.
- FSM states and transitions:
  - IDLE: on first K, go to SYNC. At the same edge, clear rx_packet, rx_error and rx_data_ready, and set rx_transfer_active.
  - SYNC: the byte must equal 0x80 (KJKJKJKK), else go to ERR. On a match, go to PID.
  - PID: the byte's upper nibble must equal the complement of its lower nibble, and the PID must be one of OUT, IN, DATA0, DATA1, ACK, NAK or STALL; else go to ERR. On a valid PID, rx_packet is loaded on the next clock.
    - Token PID: go to TOKEN.
    - Data PID: go to DATA.
    - Handshake PID: go to EOP.
  - TOKEN: receive exactly 2 bytes and discard them, then go to EOP. No CRC5 or address check.
  - DATA: on each byte_valid, drive rx_packet_data and pulse store_rx_packet_data. CRC16 bytes are stored like any other byte; CRC checking is out of scope. eop_seen on a byte boundary goes to EOP_J.
  - EOP: requires eop_seen at the next strobe, else go to ERR.
  - EOP_J: wait for J at a strobe, then go to DONE.
  - DONE: rx_transfer_active = 0. rx_data_ready = 1 if a data PID was received with at least one byte. Go to IDLE.
  - ERR: rx_error = 1. Wait until J has been held for 8 consecutive strobes (idle), then go to IDLE with rx_transfer_active = 0.
- Any state except IDLE, DONE and ERR goes to ERR on any of:
  - stuff_err
  - eop_seen mid-byte (partial bits pending)
  - a data byte arriving while buffer_occupancy >= BUF_DEPTH (that byte is not stored)
- Outputs rx_packet, rx_error and rx_data_ready hold their values until the next SYNC start.
- Simultaneous stuff_err and byte completion: the error wins and no store is issued.
- An asynchronous n_rst at any point returns to IDLE with all reset values. No partial store is issued.

Decomposition:
- Package usb_rx_pkg holds:
  - rx_pkt_t encoding: NONE=0, OUT=1, IN=2, DATA0=3, DATA1=4, ACK=5, NAK=6, STALL=7
  - PID nibble constants
  - SYNC_BYTE = 0x80
  - FSM state enum
- Sub-module usb_rx_bit_decoder contains the synchronizers, bit timer, NRZI decode, unstuffer and SE0 detection. Its outputs are bit_valid, bit_val, eop_seen and stuff_err.
- The top level contains the byte assembler and the FSM.

Test Plan:
- Reset mid-DATA packet -> all outputs return to their reset values immediately; the following valid ACK packet decodes cleanly.
- SYNC, PID 0xD2 (ACK), EOP -> rx_packet=5, rx_data_ready=0, rx_error=0, no store strobes, rx_transfer_active falls after the J.
- SYNC, DATA0 (0xC3), bytes 0xA5 0x3C, EOP -> two store pulses carrying 0xA5 then 0x3C, rx_packet=3, rx_data_ready=1.
- DATA1 payload 0xFF 0xFF with stuffed zeros inserted on the wire -> two stores of 0xFF, no error.
- Seven consecutive 1s on the wire after PID -> rx_error=1, no further stores, return to IDLE after 8 idle J bits.
- Bad PID 0xC4, or DATA0 byte sent with buffer_occupancy=64, or SE0 after 5 bits of a byte -> rx_error=1, rx_data_ready=0.
